// File: rtl/frame_pkg.sv
// Shared frame-buffer constants, pixel type and loader state encoding used by the
// loader, the display address logic and the gaussian processor.
package frame_pkg;

    localparam int unsigned IMG_W  = 160;
    localparam int unsigned IMG_H  = 120;
    localparam int unsigned ADDR_W = 15;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef logic [2:0] ld_state_t;

    localparam ld_state_t StIdle     = 3'd0;
    localparam ld_state_t StWaitSync = 3'd1;
    localparam ld_state_t StRecv     = 3'd2;
    localparam ld_state_t StLast     = 3'd3;
    localparam ld_state_t StDone     = 3'd4;

endpackage

// File: rtl/uart_frame_loader_if.sv
// Frame-buffer write port: the loader drives it, the memory (via the top-level mux) sinks it.
interface uart_frame_loader_if #(
    parameter int unsigned ADDR_W = frame_pkg::ADDR_W
);
    import frame_pkg::*;

    logic [ADDR_W-1:0] mem_address;
    pixel_t            mem_data;
    logic              mem_wren;

    modport master (output mem_address, output mem_data, output mem_wren);
    modport slave  (input  mem_address, input  mem_data, input  mem_wren);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, glitch-rejecting start bit.
module uart_rx_byte #(
    parameter int unsigned BIT_CYC = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int unsigned CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] HalfCnt = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(BIT_CYC - 1);

    localparam logic [1:0] RxIdle  = 2'd0;
    localparam logic [1:0] RxStart = 2'd1;
    localparam logic [1:0] RxData  = 2'd2;
    localparam logic [1:0] RxStop  = 2'd3;

    // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detect
    logic [2:0]       sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[1:0], uart_rx};
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            RxIdle: begin
                if (sync_q[2] && !rx_s) begin
                    state_d = RxStart;
                    cnt_d   = '0;
                end
            end
            RxStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RxData: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RxStop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == FullCnt) begin
                    valid_d = 1'b1;
                    byte_d  = shift_q;
                    ferr_d  = !rx_s;
                    state_d = RxIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 3'b111;
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_byte  = byte_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Loads a sync-prefixed raster RGB stream from UART into the column-major frame buffer.
module uart_frame_loader #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned IMG_W       = frame_pkg::IMG_W,
    parameter int unsigned IMG_H       = frame_pkg::IMG_H,
    parameter int unsigned ADDR_W      = frame_pkg::ADDR_W,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx,
    input  logic                       start,
    uart_frame_loader_if.master        mem,
    output logic                       busy,
    output logic                       load_done,
    output logic                       frame_error
);
    import frame_pkg::*;

    localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
    localparam int unsigned X_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned Y_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [X_W-1:0]   XLast    = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   YLast    = Y_W'(IMG_H - 1);
    localparam logic [TMO_W-1:0] TmoLimit = TMO_W'(TIMEOUT_CYC);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    ld_state_t         state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [7:0]        r_q, r_d;
    logic [7:0]        g_q, g_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    pixel_t            mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              frame_error_q, frame_error_d;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        r_d           = r_q;
        g_d           = g_q;
        x_d           = x_q;
        y_d           = y_q;
        addr_d        = addr_q;
        tmo_d         = tmo_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        frame_error_d = frame_error_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StWaitSync;
                    frame_error_d = 1'b0;
                end
            end
            StWaitSync: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d = StRecv;
                    phase_d = '0;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    tmo_d   = '0;
                end
            end
            StRecv: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    if (rx_ferr) begin
                        frame_error_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        case (phase_q)
                            2'd0: begin
                                r_d     = rx_byte;
                                phase_d = 2'd1;
                            end
                            2'd1: begin
                                g_d     = rx_byte;
                                phase_d = 2'd2;
                            end
                            default: begin
                                phase_d       = 2'd0;
                                mem_wren_d    = 1'b1;
                                mem_address_d = addr_q;
                                mem_data_d    = {r_q, g_q, rx_byte};
                                // Column-major walk: stepping x jumps a whole column of IMG_H
                                if (x_q != XLast) begin
                                    x_d    = x_q + X_W'(1);
                                    addr_d = addr_q + ADDR_W'(IMG_H);
                                end else if (y_q != YLast) begin
                                    x_d    = '0;
                                    y_d    = y_q + Y_W'(1);
                                    addr_d = ADDR_W'(y_q) + ADDR_W'(1);
                                end else begin
                                    state_d = StLast;
                                end
                            end
                        endcase
                    end
                end else if (tmo_q == TmoLimit) begin
                    frame_error_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            // StLast covers the final write cycle so load_done follows it by one cycle
            StLast:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            phase_q       <= '0;
            r_q           <= '0;
            g_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            tmo_q         <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            r_q           <= r_d;
            g_q           <= g_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            tmo_q         <= tmo_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign mem.mem_address = mem_address_q;
    assign mem.mem_data    = mem_data_q;
    assign mem.mem_wren    = mem_wren_q;
    assign busy            = (state_q != StIdle);
    assign load_done       = (state_q == StDone);
    assign frame_error     = frame_error_q;

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Loads a full 160x120 RGB image from a host over UART into the `vga_frame` buffer, so the display and blur pipeline work on externally supplied images. The block is the writer at the far end of the frame-memory interface that the VGA frame driver and the gaussian processor read. It receives a sync byte followed by raster-ordered R,G,B bytes. It writes one 24-bit pixel per three bytes at the buffer's column-major address (`y + x*IMG_H`). While `busy` is high, the top level gives it the memory port.

## Interface
Parameters:
- `CLK_HZ`, 50000000, clock frequency.
- `BAUD`, 115200, UART bit rate; bit period `BIT_CYC = CLK_HZ/BAUD` (integer division, 434 at defaults).
- `IMG_W`, 160, image columns.
- `IMG_H`, 120, image rows.
- `ADDR_W`, 15, memory address width.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_CYC`, 5000000, maximum inter-byte gap in RECV (100 ms).

Ports (reset rst, asynchronous, active-low; clock clk):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `uart_rx` in 1: serial input, idle high, 8N1, LSB first; asynchronous to `clk`.
- `start` in 1: single-cycle arm request.
- `mem_address` out ADDR_W: frame-buffer write address.
- `mem_data` out 24: pixel, packed as {R,G,B}, R in [23:16].
- `mem_wren` out 1: one-cycle write strobe.
- `busy` out 1: high in WAIT_SYNC and RECV; the top level muxes the memory port on this signal.
- `load_done` out 1: one-cycle pulse after the final pixel write.
- `frame_error` out 1: sticky error flag; cleared by `start` or reset.

## Operation
- **Receiver (`uart_rx_byte`)**
  - `uart_rx` passes through a 2-FF synchronizer.
  - A start bit is a falling edge; it is sampled again at `BIT_CYC/2` and a high value there rejects it as a glitch.
  - The 8 data bits are sampled at mid-bit, then the stop bit.
  - `rx_valid` pulses one cycle at the mid-stop-bit sample, with `rx_byte` and `rx_ferr` (stop bit = 0) valid in that cycle.
- **IDLE**
  - `start` moves to WAIT_SYNC and clears `frame_error`.
  - Received bytes are ignored.
- **WAIT_SYNC**
  - A byte equal to `SYNC_BYTE` moves to RECV and resets x, y, the byte phase and the address to 0.
  - Any other byte is discarded; the state holds with no timeout.
  - `rx_ferr` is ignored here.
- **RECV**
  - Phase 0 latches R, phase 1 latches G.
  - Phase 2 drives `mem_data={R,G,B}` and `mem_address=addr` and asserts `mem_wren` for one cycle.
  - After each write the pixel position advances:
    - Not the last column (`x!=IMG_W-1`): `x++`, `addr += IMG_H`.
    - Last column of a non-final row: `x=0`, `y++`, `addr = y+1`.
  - No multiplier is used for address generation.
  - Final pixel (`x=IMG_W-1`, `y=IMG_H-1`): after its write, go to DONE.
- **Errors in RECV**
  - `rx_ferr` discards the byte, sets `frame_error`, returns to IDLE with no write.
  - An inter-byte gap counter reloads on every `rx_valid`. Reaching `TIMEOUT_CYC` sets `frame_error` and returns to IDLE.
  - Pixels already written stay in memory.
- **DONE**
  - Pulses `load_done` for one cycle, then returns to IDLE.
- **Other rules**
  - `start` is ignored while `busy`.
  - Bytes arriving in DONE or IDLE are dropped.
  - Reset mid-frame: immediate return to IDLE, no further writes, partial image retained.

## Timing
- Reset values:
  - Outputs: `mem_address`=0, `mem_data`=0, `mem_wren`=0, `busy`=0, `load_done`=0, `frame_error`=0.
  - FSM: IDLE; receiver idle.
- `busy` rises the cycle after `start` is sampled.
- Stop-bit latency: `rx_valid` comes (2 + ~9.5·BIT_CYC) cycles after the start-bit falling edge on the pin.
- Write latency: `mem_wren` is registered, asserted the cycle after the B byte's `rx_valid`; `mem_address` and `mem_data` are stable in the same cycle.
- Spacing: consecutive writes are at least 3 byte-times apart. No back-pressure is needed; the memory accepts one write per cycle.
- Completion, all one cycle apart after the final write's `mem_wren` cycle:
  1. `load_done` pulses the next cycle.
  2. `busy` falls the cycle after the `load_done` pulse.
- Error exit: `frame_error` and `busy`=0 take effect together in the cycle after the error is detected.
- Counter widths: x and y `$clog2` of their limits; baud counter `$clog2(BIT_CYC)`; timeout counter `$clog2(TIMEOUT_CYC+1)`.

## Structure
- A shared package `frame_pkg` holds `IMG_W`, `IMG_H`, `ADDR_W`, the pixel type (24-bit {R,G,B}) and the loader FSM state enum. The gaussian processor and display address logic use the same constants.
- Sub-module `uart_rx_byte` (synchronizer, baud counter, shift register, `rx_valid`/`rx_ferr`); the loader FSM, address generator and timeout counter live in the top of this block.

## Test plan
Sim parameters: `IMG_W`=4, `IMG_H`=3, `BIT_CYC`=16 (`CLK_HZ`=16·`BAUD`), `TIMEOUT_CYC`=2000.
1. **Full load:** `start`, 0xA5, then 36 bytes where pixel n = {n, n+0x40, n+0x80}
   - exactly 12 writes in raster order;
   - addresses 0,3,6,9,1,4,7,10,2,5,8,11, e.g. pixel 5 (x=1,y=1) at address 4 with data 0x054585;
   - `load_done` pulses once, then `busy`=0.
2. **Sync hunt:** bytes 0x00, 0x5A, then 0xA5 and a full frame
   - no writes before the 0xA5;
   - first write at address 0.
3. **Framing error:** stop bit forced 0 on byte 7 (pixel 2's G)
   - writes only at addresses 0 and 3;
   - `frame_error`=1, `busy`=0;
   - next `start` clears `frame_error`.
4. **Timeout:** send 0xA5 plus 5 bytes, then idle 2000 cycles
   - one write at address 0;
   - `frame_error`=1, return to IDLE.
5. **Ignored inputs:** `start` pulses during RECV, and a 4-cycle low glitch on `uart_rx`
   - no effect on the FSM;
   - no byte is received from the glitch.
6. **Reset mid-frame:** `rst` low after pixel 6
   - all outputs 0 immediately;
   - no writes for the rest of the byte stream.
